seq_gen_scheduler: RTL and testbench
====================================

// Module: seq_gen_scheduler
// PURPOSE
//  Time-shares one sequence_gen FSM among NREQ requesters. Each job is an LEN-bit input
//  string: it is fed to the generator's I one bit per cycle, and the generator's O is
//  captured bit-for-bit. Round-robin arbitration picks the next job. The generator is
//  cleared between jobs, so every job starts from state 000.
//  Sits between requester logic and a single sequence_gen instance, which is wired
//  outside this block.
// PARAMETERS
//  NREQ  2  number of requesters, >=2
//  LEN   8  bits per job, >=2
//  ID_W  derived: max(1,$clog2(NREQ)); not overridable
// PORTS
//  clk        in   1         single clock, rising edge
//  reset      in   1         asynchronous, active-high; clears all state immediately
//  req_valid  in   NREQ      requester r has a job pending
//  req_ready  out  NREQ      one-hot grant; accept occurs when req_valid[r]&req_ready[r]
//  req_data   in   NREQ*LEN  job of r at [r*LEN +: LEN]; bit0 is fed first
//  rsp_valid  out  1         result available
//  rsp_ready  in   1         consumer accepts the result
//  rsp_id     out  ID_W      requester index of the result
//  rsp_data   out  LEN       captured O bits; bit k = O in feed cycle k
//  gen_reset  out  1         drives sequence_gen reset (its synchronous reset)
//  gen_i      out  1         drives sequence_gen I
//  gen_o      in   1         sequence_gen O (Mealy: depends on current state and gen_i)
//  busy       out  1         state != IDLE
// BEHAVIOUR
//  - Reset values: state IDLE, cnt 0, rr_ptr 0, job 0, rsp_id 0, rsp_data 0, rsp_valid 0.
//    While reset is high, req_ready = 0 and gen_reset = 1.
//  - FSM states: IDLE, RUN, DONE.
//  - IDLE: gen_reset=1. Grant is combinational: the first r with req_valid[r]=1, searching
//    from rr_ptr upward with wrap. req_ready[grant]=1 only in IDLE; all other ready bits 0.
//    On accept: latch req_data slice and id, set rr_ptr=(grant+1)%NREQ and cnt=0, go to RUN.
//    With no valid request, stay in IDLE.
//  - RUN: gen_reset=0, gen_i=job[cnt]. Each posedge stores rsp_data[cnt]<=gen_o and
//    increments cnt. At cnt==LEN-1 go to DONE. Exactly LEN cycles.
//  - DONE: rsp_valid=1; gen_reset=1; rsp_id/rsp_data stay stable until the handshake.
//    When rsp_ready=1, go to IDLE.
//  - gen_i = 0 outside RUN. gen_reset and gen_i are decoded from registered state only,
//    with no path from req_*.
//  - Latency: accept in cycle 0, RUN in cycles 1..LEN, rsp_valid first high in cycle LEN+1.
//  - Throughput: at most one job per LEN+2 cycles. The DONE->IDLE cycle is mandatory, with
//    no bypass, so the generator always sees at least 2 reset edges between jobs.
//  - Requester rule: req_valid stays held and req_data stays stable until accept.
//    Dropping req_valid before accept withdraws the job legally.
//  - Simultaneous events: rsp_ready and req_valid together in DONE -> the new job is
//    accepted in the following IDLE cycle. Several valid requests -> the round-robin
//    winner is served and the others wait.
//  - Reset mid-RUN or mid-DONE: the job and result are discarded, with no rsp_valid pulse.
//    The requester must resubmit.
//  - Width rule: cnt is $clog2(LEN) bits and never exceeds LEN-1. rr_ptr < NREQ.
// STRUCTURE
//  - Package seq_gen_pkg: state enum {IDLE,RUN,DONE}, function clog2_min1 for ID_W.
//  - Sub-module rr_arbiter #(N): inputs req, ptr; outputs one-hot gnt, gnt_idx, any.
//    Purely combinational.
//  - Top level holds the FSM, the job/result shift-free registers, cnt and rr_ptr.
// TESTING  (bench instantiates sequence_gen on gen_*; NREQ=2, LEN=8)
//  1 r0 data 8'h00 -> rsp_id 0, rsp_data 8'h00, rsp_valid in cycle 9 after accept.
//  2 r0 data 8'h01 -> rsp_data 8'h31 (O pattern 1,0,0,0,1,1,0,0).
//    r0 data 8'h03 -> also 8'h31 (I ignored inside pattern).
//  3 r1 data 8'h41 -> 8'h71; r1 data 8'hFF -> 8'h71.
//    gen_reset is high in every non-RUN cycle.
//  4 r0 and r1 both valid and held from reset -> order r0,r1,r0,r1.
//    Each req_ready pulse is 1 cycle, and the grants are 10 cycles apart when rsp_ready=1.
//  5 rsp_ready held 0 for 5 cycles in DONE -> rsp_valid/rsp_data stable, busy=1,
//    and no req_ready during that time.
//  6 Assert reset in RUN cycle 4 -> next sample: state IDLE, rsp_valid 0, gen_reset 1.
//    Resubmitting 8'h01 then yields 8'h31.

Source files
------------

// File: rtl/seq_gen_pkg.sv
// Shared types for the sequence_gen time-sharing scheduler.
// State encoding and the id-width helper.
package seq_gen_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted
// request at or above ptr, wrapping around.
module rr_arbiter
  import seq_gen_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = clog2_min1(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  always_comb begin
    logic [IW-1:0] idx;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = '0;
    for (int i = 0; i < N; i++) begin
      idx = IW'((int'(ptr) + i) % N);
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt_idx  = idx;
        gnt[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_gen_scheduler.sv
// Time-shares one external sequence_gen among NREQ
// requesters, one LEN-bit job at a time.
module seq_gen_scheduler
  import seq_gen_pkg::*;
#(
  parameter  int NREQ = 2,
  parameter  int LEN  = 8,
  localparam int ID_W = clog2_min1(NREQ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*LEN-1:0] req_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ID_W-1:0]   rsp_id,
  output logic [LEN-1:0]    rsp_data,
  output logic              gen_reset,
  output logic              gen_i,
  input  logic              gen_o,
  output logic              busy
);

  localparam int CW = $clog2(LEN);
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);
  localparam logic [ID_W-1:0] ID_MAX = ID_W'(NREQ - 1);

  state_t          state;
  state_t          state_n;
  logic [CW-1:0]   cnt;
  logic [ID_W-1:0] rr_ptr;
  logic [LEN-1:0]  job;
  logic [NREQ-1:0] gnt;
  logic [ID_W-1:0] gnt_idx;
  logic            any;
  logic            take;

  rr_arbiter #(
    .N(NREQ)
  ) u_arb (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .gnt    (gnt),
    .gnt_idx(gnt_idx),
    .any    (any)
  );

  assign take = (state == IDLE) && any;
  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // gen_* decode from state only; no req_* path
  always_comb begin
    state_n   = state;
    req_ready = '0;
    rsp_valid = 1'b0;
    gen_reset = 1'b1;
    gen_i     = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = reset ? '0 : gnt;
        if (any) state_n = RUN;
      end
      RUN: begin
        gen_reset = 1'b0;
        gen_i     = job[cnt];
        if (cnt == LAST) state_n = DONE;
      end
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      rr_ptr   <= '0;
      job      <= '0;
      rsp_id   <= '0;
      rsp_data <= '0;
    end else if (take) begin
      job    <= req_data[int'(gnt_idx)*LEN +: LEN];
      rsp_id <= gnt_idx;
      rr_ptr <= (gnt_idx == ID_MAX) ? '0 : gnt_idx + 1'b1;
      cnt    <= '0;
    end else if (state == RUN) begin
      rsp_data[cnt] <= gen_o;
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_gen_scheduler.sv
// Directed bench for seq_gen_scheduler with a
// behavioural sequence_gen on the gen_* pins.
module tb_seq_gen_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [7:0]  rsp_data;
  logic        gen_reset;
  logic        gen_i;
  logic        gen_o;
  logic        busy;

  int n_chk = 0;
  int n_pass = 0;
  int viol = 0;
  int cyc = 0;

  seq_gen_scheduler #(
    .NREQ(2),
    .LEN (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_data (req_data),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id   (rsp_id),
    .rsp_data (rsp_data),
    .gen_reset(gen_reset),
    .gen_i    (gen_i),
    .gen_o    (gen_o),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // sequence_gen: I=1 in state 0 emits 1, then 0,0,0,1,1 ignoring I
  logic [2:0] gst;
  always @(posedge clk) begin
    if (gen_reset)     gst <= 3'd0;
    else if (gst == 0) gst <= gen_i ? 3'd1 : 3'd0;
    else if (gst == 5) gst <= 3'd0;
    else               gst <= gst + 3'd1;
  end
  assign gen_o = (gst == 0) ? gen_i : (gst == 4 || gst == 5);

  always @(negedge clk) begin
    if (busy && !rsp_valid) begin
      if (gen_reset) viol++;
    end else if (!gen_reset || gen_i) begin
      viol++;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  task automatic do_job(input int r,
                        input logic [7:0] d,
                        input logic [7:0] exp,
                        input string tag);
    int t;
    int lat;
    rsp_ready = 1'b0;
    req_data[r*8 +: 8] = d;
    req_valid[r] = 1'b1;
    #1;
    t = 0;
    while (!req_ready[r] && t < 20) begin
      @(negedge clk);
      #1;
      t++;
    end
    check({tag, "_acc"}, 32'(t < 20), 32'd1);
    @(negedge clk);
    req_valid[r] = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'd9);
    check({tag, "_id"}, 32'(rsp_id), 32'(r));
    check({tag, "_data"}, 32'(rsp_data), 32'(exp));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  int gid[$];
  int gcy[$];

  initial begin
    int t;
    reset     = 1'b1;
    req_valid = 2'b00;
    req_data  = 16'h0000;
    rsp_ready = 1'b0;
    @(negedge clk);
    #1;
    check("rst_out",
          {busy, rsp_valid, rsp_id, rsp_data, req_ready,
           gen_reset, gen_i},
          {1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 1'b0});
    @(negedge clk);
    reset = 1'b0;

    do_job(0, 8'h00, 8'h00, "j00");
    do_job(0, 8'h01, 8'h31, "j01");
    do_job(0, 8'h03, 8'h31, "j03");
    do_job(1, 8'h41, 8'h71, "j41");
    do_job(1, 8'hFF, 8'h71, "jff");

    // result held while consumer stalls
    req_data = {8'h41, 8'h00};
    req_valid = 2'b10;
    #1;
    t = 0;
    while (!req_ready[1] && t < 20) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("stall_acc", 32'(t < 20), 32'd1);
    @(negedge clk);
    req_valid = 2'b01;
    t = 0;
    while (!rsp_valid && t < 30) begin
      @(negedge clk);
      t++;
    end
    check("stall_id", 32'(rsp_id), 32'd1);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_hold",
            {rsp_valid, busy, req_ready, rsp_data},
            {1'b1, 1'b1, 2'b00, 8'h71});
      @(negedge clk);
    end
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    check("stall_idle", 32'(busy), 32'd0);

    // reset in the middle of a job
    @(negedge clk);
    req_data[7:0] = 8'h01;
    req_valid = 2'b01;
    #1;
    t = 0;
    while (!req_ready[0] && t < 20) begin
      @(negedge clk);
      #1;
      t++;
    end
    @(negedge clk);
    req_valid = 2'b00;
    repeat (3) @(negedge clk);
    check("mid_run", 32'(busy && !rsp_valid), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst",
          {busy, rsp_valid, gen_reset, req_ready},
          {1'b0, 1'b0, 1'b1, 2'b00});
    @(negedge clk);
    reset = 1'b0;
    do_job(0, 8'h01, 8'h31, "resub");

    // two requesters held from reset
    @(negedge clk);
    reset = 1'b1;
    req_valid = 2'b11;
    req_data = {8'hFF, 8'h01};
    rsp_ready = 1'b1;
    #1;
    check("rr_rst_rdy", 32'(req_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 45; i++) begin
      #1;
      if (|(req_valid & req_ready)) begin
        gid.push_back(req_ready[1] ? 1 : 0);
        gcy.push_back(cyc);
      end
      @(negedge clk);
    end
    check("rr_cnt", 32'(gid.size() >= 4), 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (i < gid.size()) begin
        check("rr_order", 32'(gid[i]), 32'(i % 2));
        if (i > 0)
          check("rr_gap", 32'(gcy[i] - gcy[i-1]), 32'd10);
      end
    end
    req_valid = 2'b00;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("gen_ctl", 32'(viol), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
